// File: rtl/uart_pkg.sv
// Shared types and board-level timing constants for the UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam int unsigned default_divisor = 434;
    localparam int unsigned clock_hz        = 50_000_000;
    localparam int unsigned baud            = 115200;

endpackage

// File: rtl/uart_transmitter_if.sv
// Payload handshake between a byte producer (master) and the transmitter (slave).
interface uart_transmitter_if #(
    parameter int unsigned data_width = 8
) ();

    logic [data_width-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..divisor-1 while enabled; tick marks the last cycle of a bit.
module uart_baud_counter #(
    parameter int unsigned divisor = 434
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntWidth = (divisor > 1) ? $clog2(divisor) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(divisor - 1);

    if (divisor < 2) begin : g_bad_divisor
        $error("uart_baud_counter: divisor must be at least 2");
    end

    logic [CntWidth-1:0] cnt_q, cnt_d;

    // tick must not depend on restart: restart is derived from tick via the handshake.
    assign tick = enable && (cnt_q == CntLast);

    // Next count: restart wins, otherwise count and wrap on the bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one payload per handshake as start, data (LSB first),
// optional parity and stop bits, with back-to-back frames accepted in the last stop cycle.
module uart_transmitter import uart_pkg::*; #(
    parameter int unsigned divisor    = default_divisor,
    parameter int unsigned data_width = 8,
    parameter bit          parity_en  = 1'b0,
    parameter bit          parity_odd = 1'b0,
    parameter int unsigned stop_bits  = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    uart_transmitter_if.slave  tx_if,
    output logic               tx,
    output logic               busy,
    output logic               done
);

    localparam int unsigned BitWidth = $clog2(data_width + 1);
    localparam logic [BitWidth-1:0] LastData = BitWidth'(data_width - 1);
    localparam logic [BitWidth-1:0] LastStop = BitWidth'(stop_bits - 1);

    if (divisor < 2) begin : g_bad_divisor
        $error("uart_transmitter: divisor must be at least 2");
    end
    if (data_width < 5 || data_width > 9) begin : g_bad_width
        $error("uart_transmitter: data_width must be 5..9");
    end
    if (stop_bits != 1 && stop_bits != 2) begin : g_bad_stop
        $error("uart_transmitter: stop_bits must be 1 or 2");
    end

    uart_state_e           state_q, state_d;
    logic [BitWidth-1:0]   bit_cnt_q, bit_cnt_d;
    logic [data_width-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  tick;
    logic                  last_stop;
    logic                  tx_ready;
    logic                  transfer;

    uart_baud_counter #(
        .divisor (divisor)
    ) u_baud (
        .clock   (clock),
        .reset_n (reset_n),
        .restart (transfer),
        .enable  (busy),
        .tick    (tick)
    );

    // Handshake and status outputs, combinational from state and counters.
    always_comb begin
        last_stop = (state_q == StStop) && tick && (bit_cnt_q == LastStop);
        tx_ready  = (state_q == StIdle) || last_stop;
        transfer  = tx_if.tx_valid && tx_ready;
        busy      = (state_q != StIdle);
        done      = last_stop;
        tx        = tx_q;
    end

    assign tx_if.tx_ready = tx_ready;

    // Next state; tx_d is the line level for the following cycle so the pin comes from a flop.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        unique case (state_q)
            StIdle: ;
            StStart: begin
                if (tick) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LastData) begin
                        bit_cnt_d = '0;
                        if (parity_en) begin
                            state_d = StParity;
                            tx_d    = parity_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    state_d   = StStop;
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                end
            end
            StStop: begin
                if (tick) begin
                    if (bit_cnt_q == LastStop) begin
                        state_d   = StIdle;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // A transfer is only possible in idle or the last stop cycle; it always starts a frame.
        if (transfer) begin
            state_d   = StStart;
            bit_cnt_d = '0;
            shift_d   = tx_if.tx_data;
            parity_d  = (^tx_if.tx_data) ^ parity_odd;
            tx_d      = 1'b0;
        end
    end

    // State registers; asynchronous reset returns the line high at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
        end
    end

endmodule
